mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 117 +++++++++++
 tb/tb_mem_copy_dma.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bus-initiator word copier (read, read-hold, write per word).
// Ports: clk, reset (async low), start/abort, src_addr/dst_addr/len in;
//   busy, done, count, mem_cmd, mem_addr, write_data out; read_data in.
module mem_copy_dma (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [8:0]  src_addr,
   input  logic [8:0]  dst_addr,
   input  logic [8:0]  len,
   output logic        busy,
   output logic        done,
   output logic [8:0]  count,
   output logic [1:0]  mem_cmd,
   output logic [8:0]  mem_addr,
   output logic [15:0] write_data,
   input  logic [15:0] read_data
);

   localparam logic [1:0] MREAD  = 2'd1;
   localparam logic [1:0] MWRITE = 2'd2;
   localparam logic [1:0] MNONE  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR,
      S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  src_q, src_d;
   logic [8:0]  dst_q, dst_d;
   logic [8:0]  rem_q, rem_d;
   logic [8:0]  count_q, count_d;
   logic [15:0] data_q, data_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      rem_d    = rem_q;
      count_d  = count_q;
      data_d   = data_q;
      busy     = 1'b0;
      done     = 1'b0;
      mem_cmd  = MNONE;
      mem_addr = src_q;
      unique case (state_q)
         S_IDLE: begin
            // abort outranks a simultaneous start
            if (start && !abort) begin
               src_d   = src_addr;
               dst_d   = dst_addr;
               rem_d   = len;
               count_d = '0;
               state_d = (len == '0) ? S_FIN : S_RD_ADDR;
            end
         end
         S_RD_ADDR: begin
            busy    = 1'b1;
            mem_cmd = MREAD;
            state_d = abort ? S_IDLE : S_RD_DATA;
         end
         S_RD_DATA: begin
            // MREAD held so the memory keeps driving read_data
            busy    = 1'b1;
            mem_cmd = MREAD;
            data_d  = read_data;
            state_d = abort ? S_IDLE : S_WR;
         end
         S_WR: begin
            // the write lands at this edge even on abort, so it is counted
            busy     = 1'b1;
            mem_cmd  = MWRITE;
            mem_addr = dst_q;
            src_d    = src_q + 9'd1;
            dst_d    = dst_q + 9'd1;
            count_d  = count_q + 9'd1;
            rem_d    = rem_q - 9'd1;
            if (abort)
               state_d = S_IDLE;
            else
               state_d = (rem_q == 9'd1) ? S_FIN : S_RD_ADDR;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign count      = count_q;
   assign write_data = data_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: scoreboard bench for mem_copy_dma.
// Stimulus pushes expected bus beats and done cycles; a monitor checks them.
module tb_mem_copy_dma;

   localparam logic [1:0] MREAD  = 2'd1;
   localparam logic [1:0] MWRITE = 2'd2;
   localparam logic [1:0] MNONE  = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [8:0]  src_addr = '0;
   logic [8:0]  dst_addr = '0;
   logic [8:0]  len = '0;
   logic        busy;
   logic        done;
   logic [8:0]  count;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [15:0] read_data = '0;

   logic [15:0] ram    [512];
   logic [15:0] shadow [512];

   typedef struct packed {
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [15:0] data;
   } bus_t;

   bus_t bus_q[$];
   int   done_q[$];
   bus_t e;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;
   int   done_seen = 0;
   int   busy_cyc = 0;

   mem_copy_dma dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .count(count),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .write_data(write_data), .read_data(read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_cmd == MREAD) read_data <= ram[mem_addr];
      if (mem_cmd == MWRITE) ram[mem_addr] <= write_data;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (busy) busy_cyc++;
      if (reset && mem_cmd != MNONE) begin
         if (bus_q.size() == 0) begin
            checks++;
            $display("FAIL bus_unexpected: got cmd %0d addr %0h expected none",
                     mem_cmd, mem_addr);
         end else begin
            e = bus_q.pop_front();
            chk("bus_cmd", {30'd0, mem_cmd}, {30'd0, e.cmd});
            chk("bus_addr", {23'd0, mem_addr}, {23'd0, e.addr});
            if (e.cmd == MWRITE)
               chk("bus_wdata", {16'd0, write_data}, {16'd0, e.data});
         end
      end
      if (done) begin
         done_seen++;
         if (done_q.size() == 0) begin
            checks++;
            $display("FAIL done_unexpected: got done at cycle %0d expected none",
                     cyc);
         end else begin
            chk("done_cycle", cyc, done_q.pop_front());
         end
      end
   end

   function automatic bus_t mk(input logic [1:0] c, input logic [8:0] a,
                               input logic [15:0] d);
      bus_t b;
      b.cmd  = c;
      b.addr = a;
      b.data = d;
      return b;
   endfunction

   task automatic push_reads(input logic [8:0] a);
      bus_q.push_back(mk(MREAD, a, 16'h0));
      bus_q.push_back(mk(MREAD, a, 16'h0));
   endtask

   task automatic push_words(input logic [8:0] s, input logic [8:0] d,
                             input int n);
      logic [8:0] sa, da;
      for (int i = 0; i < n; i++) begin
         sa = s + 9'(i);
         da = d + 9'(i);
         push_reads(sa);
         shadow[da] = shadow[sa];
         bus_q.push_back(mk(MWRITE, da, shadow[da]));
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      int b;
      b = done_seen;
      for (int i = 0; i < budget && done_seen == b; i++) @(negedge clk);
      if (done_seen == b) begin
         checks++;
         $display("FAIL %s_timeout: got no done expected done", name);
      end
      @(posedge clk);
      #1;
   endtask

   // full transfer: bus beats and done cycle predicted before start
   task automatic run(input string name, input logic [8:0] s,
                      input logic [8:0] d, input int n);
      @(posedge clk);
      #1;
      busy_cyc = 0;
      push_words(s, d, n);
      done_q.push_back(cyc + 3 * n + 1);
      src_addr = s;
      dst_addr = d;
      len = 9'(n);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(name, 3 * n + 10);
      chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
      chk({name, "_count"}, {23'd0, count}, 32'(n));
      chk({name, "_busy_cycles"}, busy_cyc, 3 * n);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         ram[i]    = 16'hA000 + 16'(i);
         shadow[i] = 16'hA000 + 16'(i);
      end
      ram[9'h10]    = 16'hBEEF;
      shadow[9'h10] = 16'hBEEF;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_count", {23'd0, count}, 32'd0);
      chk("rst_cmd", {30'd0, mem_cmd}, 32'd3);
      chk("rst_addr", {23'd0, mem_addr}, 32'd0);
      chk("rst_wdata", {16'd0, write_data}, 32'd0);
      reset = 1'b1;

      run("single", 9'h10, 9'h20, 1);
      chk("single_ram", {16'd0, ram[9'h20]}, 32'hBEEF);

      run("block", 9'h000, 9'h080, 5);
      for (int i = 0; i < 5; i++)
         chk("block_ram", {16'd0, ram[9'h80 + 9'(i)]}, 32'hA000 + 32'(i));

      run("zero", 9'h030, 9'h031, 0);
      chk("zero_ram", {16'd0, ram[9'h31]}, 32'hA031);

      run("wrap", 9'h1FE, 9'h0FE, 3);
      chk("wrap_ram0", {16'd0, ram[9'h0FE]}, 32'hA1FE);
      chk("wrap_ram1", {16'd0, ram[9'h0FF]}, 32'hA1FF);
      chk("wrap_led", {16'd0, ram[9'h100]}, 32'hA000);

      // abort in RD_DATA of word 3, with a stray start while busy
      @(posedge clk);
      #1;
      push_words(9'h040, 9'h0C0, 2);
      push_reads(9'h042);
      src_addr = 9'h040;
      dst_addr = 9'h0C0;
      len = 9'd6;
      start = 1'b1;
      @(posedge clk);
      #1;
      src_addr = 9'h1F0;
      dst_addr = 9'h010;
      len = 9'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_cmd", {30'd0, mem_cmd}, 32'd3);
      chk("abort_count", {23'd0, count}, 32'd2);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_w1", {16'd0, ram[9'h0C0]}, 32'hA040);
      chk("abort_w2", {16'd0, ram[9'h0C1]}, 32'hA041);
      chk("abort_w3", {16'd0, ram[9'h0C2]}, 32'hA0C2);

      // abort and start together in IDLE
      src_addr = 9'h060;
      dst_addr = 9'h0E0;
      len = 9'd2;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      chk("abst_busy", {31'd0, busy}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("abst_count", {23'd0, count}, 32'd2);

      // reset during WR of word 2
      push_words(9'h050, 9'h0D0, 1);
      push_reads(9'h051);
      src_addr = 9'h050;
      dst_addr = 9'h0D0;
      len = 9'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_cmd", {30'd0, mem_cmd}, 32'd2);
      chk("mid_addr", {23'd0, mem_addr}, 32'h0D1);
      reset = 1'b0;
      #1;
      chk("mid_rst_cmd", {30'd0, mem_cmd}, 32'd3);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_count", {23'd0, count}, 32'd0);
      chk("mid_rst_addr", {23'd0, mem_addr}, 32'd0);
      chk("mid_rst_wdata", {16'd0, write_data}, 32'd0);
      @(posedge clk);
      #1;
      chk("mid_w1", {16'd0, ram[9'h0D0]}, 32'hA050);
      chk("mid_w2", {16'd0, ram[9'h0D1]}, 32'hA0D1);
      reset = 1'b1;

      run("post_rst", 9'h10, 9'h21, 1);
      chk("post_rst_ram", {16'd0, ram[9'h21]}, 32'hBEEF);

      repeat (4) @(posedge clk);
      #1;
      chk("bus_q_left", bus_q.size(), 32'd0);
      chk("done_q_left", done_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
